// File: rtl/u765_sd_pkg.sv
// rtl/u765_sd_pkg.sv - shared types and constants for the u765 SD arbiter
// Contents:
//   arb_state_t      arbiter FSM states (IDLE, ISSUE, XFER, GAP)
//   NUM_RQ           number of requester ports
//   DEFAULT_TIMEOUT  default sd_ack rise timeout in clk_sys cycles
package u765_sd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam int NUM_RQ = 2;

    localparam logic [23:0] DEFAULT_TIMEOUT = 24'd10000000;

endpackage

// File: rtl/u765_sd_rr_pick.sv
// rtl/u765_sd_rr_pick.sv - combinational two-way round-robin picker
// Ports:
//   req          per-port request flags
//   last         port that won the previous grant
//   grant_valid  at least one port is requesting
//   winner       selected port (the port that is not last on a tie)
module u765_sd_rr_pick
    import u765_sd_pkg::*;
(
    input  logic [NUM_RQ-1:0] req,
    input  logic              last,
    output logic              grant_valid,
    output logic              winner
);

    always_comb begin
        grant_valid = |req;
        // On a tie the port that did not win last time goes next;
        // otherwise the only requester wins (port 0 if none).
        winner      = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/u765_sd_arbiter.sv
// rtl/u765_sd_arbiter.sv - shares the host SD block interface between two sector requesters
// Optional feature macro: U765_SD_TIMEOUT_EN (abort ISSUE when sd_ack never rises)
// Ports:
//   clk_sys, reset                     clock and synchronous active-high reset
//   rq0_* / rq1_*                      requester ports (lba, rd, wr, ack, buff_wr, buff_din)
//   sd_lba, sd_rd, sd_wr, sd_buff_din  granted request towards the host
//   sd_ack, sd_buff_wr                 host handshake, routed back to the owner
//   busy, owner                        transaction in progress, current or last owner
//   timeout_err                        one-cycle pulse on an aborted ISSUE
module u765_sd_arbiter
    import u765_sd_pkg::*;
#(
    parameter int          LBA_W   = 32,
    parameter logic [23:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk_sys,
    input  logic             reset,

    input  logic [LBA_W-1:0] rq0_lba,
    input  logic [1:0]       rq0_rd,
    input  logic [1:0]       rq0_wr,
    output logic             rq0_ack,
    output logic             rq0_buff_wr,
    input  logic [7:0]       rq0_buff_din,

    input  logic [LBA_W-1:0] rq1_lba,
    input  logic [1:0]       rq1_rd,
    input  logic [1:0]       rq1_wr,
    output logic             rq1_ack,
    output logic             rq1_buff_wr,
    input  logic [7:0]       rq1_buff_din,

    output logic [LBA_W-1:0] sd_lba,
    output logic [1:0]       sd_rd,
    output logic [1:0]       sd_wr,
    input  logic             sd_ack,
    input  logic             sd_buff_wr,
    output logic [7:0]       sd_buff_din,

    output logic             busy,
    output logic             owner,
    output logic             timeout_err
);

    arb_state_t       state, state_n;
    logic [LBA_W-1:0] lba_n;
    logic [1:0]       rd_n, wr_n;
    logic             busy_n, owner_n, last, last_n;

    logic [1:0]       req;
    logic             grant_valid, winner;
    logic [1:0]       win_rd, win_wr;
    logic             routed;

`ifdef U765_SD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             tmo_n;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    assign req = {(|rq1_rd) | (|rq1_wr), (|rq0_rd) | (|rq0_wr)};

    u765_sd_rr_pick u_pick (
        .req         (req),
        .last        (last),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    assign win_rd = winner ? rq1_rd : rq0_rd;
    assign win_wr = winner ? rq1_wr : rq0_wr;

    always_comb begin
        state_n = state;
        lba_n   = sd_lba;
        rd_n    = sd_rd;
        wr_n    = sd_wr;
        busy_n  = busy;
        owner_n = owner;
        last_n  = last;
`ifdef U765_SD_TIMEOUT_EN
        cnt_n   = cnt;
        tmo_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Waiting for sd_ack low keeps a host ack left over from a
                // reset mid-transfer from being mistaken for a new one.
                if (!sd_ack && grant_valid) begin
                    owner_n = winner;
                    last_n  = winner;
                    busy_n  = 1'b1;
                    lba_n   = winner ? rq1_lba : rq0_lba;
                    if (|win_rd) begin
                        rd_n = win_rd;
                        wr_n = 2'b00;
                    end else begin
                        rd_n = 2'b00;
                        wr_n = win_wr;
                    end
`ifdef U765_SD_TIMEOUT_EN
                    cnt_n = '0;
`endif
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    rd_n    = 2'b00;
                    wr_n    = 2'b00;
                    state_n = XFER;
                end
`ifdef U765_SD_TIMEOUT_EN
                // Abort on the edge where the counter would reach TIMEOUT,
                // i.e. after TIMEOUT cycles spent in ISSUE.
                else if (cnt == CNT_W'(TIMEOUT - 24'd1)) begin
                    rd_n    = 2'b00;
                    wr_n    = 2'b00;
                    tmo_n   = 1'b1;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            XFER: begin
                if (!sd_ack) begin
                    state_n = GAP;
                end
            end
            GAP: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state  <= IDLE;
            sd_lba <= '0;
            sd_rd  <= 2'b00;
            sd_wr  <= 2'b00;
            busy   <= 1'b0;
            owner  <= 1'b0;
            last   <= 1'b1;
`ifdef U765_SD_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            sd_lba <= lba_n;
            sd_rd  <= rd_n;
            sd_wr  <= wr_n;
            busy   <= busy_n;
            owner  <= owner_n;
            last   <= last_n;
`ifdef U765_SD_TIMEOUT_EN
            cnt         <= cnt_n;
            timeout_err <= tmo_n;
`endif
        end
    end

    // Host handshake reaches only the owner, and only while its
    // transaction is live.
    assign routed      = (state == ISSUE) || (state == XFER);
    assign rq0_ack     = routed && !owner && sd_ack;
    assign rq1_ack     = routed &&  owner && sd_ack;
    assign rq0_buff_wr = routed && !owner && sd_buff_wr;
    assign rq1_buff_wr = routed &&  owner && sd_buff_wr;
    assign sd_buff_din = (routed && owner) ? rq1_buff_din : rq0_buff_din;

endmodule

// File: tb/tb_u765_sd_arbiter.sv
// tb/tb_u765_sd_arbiter.sv - scoreboard bench for u765_sd_arbiter
module tb_u765_sd_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] rq0_lba, rq1_lba;
    logic [1:0]  rq0_rd, rq0_wr, rq1_rd, rq1_wr;
    logic        rq0_ack, rq1_ack, rq0_buff_wr, rq1_buff_wr;
    logic [7:0]  rq0_buff_din, rq1_buff_din;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        busy, owner, timeout_err;

    u765_sd_arbiter #(.LBA_W(32), .TIMEOUT(24'd20)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .rq0_lba      (rq0_lba),
        .rq0_rd       (rq0_rd),
        .rq0_wr       (rq0_wr),
        .rq0_ack      (rq0_ack),
        .rq0_buff_wr  (rq0_buff_wr),
        .rq0_buff_din (rq0_buff_din),
        .rq1_lba      (rq1_lba),
        .rq1_rd       (rq1_rd),
        .rq1_wr       (rq1_wr),
        .rq1_ack      (rq1_ack),
        .rq1_buff_wr  (rq1_buff_wr),
        .rq1_buff_din (rq1_buff_din),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .busy         (busy),
        .owner        (owner),
        .timeout_err  (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        owner;
        logic [31:0] lba;
        logic [1:0]  rd;
        logic [1:0]  wr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   lat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input logic o, input logic [31:0] l, input logic [1:0] r, input logic [1:0] w);
        exp_t e;
        e.owner = o; e.lba = l; e.rd = r; e.wr = w;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Waits for a grant, checks it against the scoreboard, then plays the
    // host side: ack after a few cycles, nbytes buff_wr pulses, ack low.
    task automatic serve(input int nbytes, input bit drop_req);
        exp_t e;
        int   c_own, c_oth, din_bad;
        logic [7:0] exp_din;
        lat = 0;
        while (sd_rd == 2'b00 && sd_wr == 2'b00 && lat < 20) begin
            tick();
            lat++;
        end
        if (sd_rd == 2'b00 && sd_wr == 2'b00) begin
            chk("grant_wait", 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("owner", owner, e.owner);
        chk("lba", sd_lba, e.lba);
        chk("sd_rd", sd_rd, e.rd);
        chk("sd_wr", sd_wr, e.wr);
        chk("busy", busy, 1);
        repeat (2) tick();
        chk("strobe_hold", {sd_rd, sd_wr}, {e.rd, e.wr});
        sd_ack = 1'b1;
        #1;
        chk("ack_own", e.owner ? rq1_ack : rq0_ack, 1);
        chk("ack_other", e.owner ? rq0_ack : rq1_ack, 0);
        if (drop_req) begin
            if (e.owner) begin rq1_rd = 2'b00; rq1_wr = 2'b00; end
            else begin rq0_rd = 2'b00; rq0_wr = 2'b00; end
        end
        tick();
        chk("strobe_drop", {sd_rd, sd_wr}, 4'b0000);
        c_own = 0; c_oth = 0; din_bad = 0;
        for (int i = 0; i < nbytes; i++) begin
            rq0_buff_din = 8'($urandom);
            rq1_buff_din = 8'($urandom);
            sd_buff_wr   = 1'b1;
            #1;
            exp_din = e.owner ? rq1_buff_din : rq0_buff_din;
            if (sd_buff_din !== exp_din) din_bad++;
            if ((e.owner ? rq1_buff_wr : rq0_buff_wr) === 1'b1) c_own++;
            if ((e.owner ? rq0_buff_wr : rq1_buff_wr) === 1'b1) c_oth++;
            tick();
            sd_buff_wr = 1'b0;
            tick();
        end
        chk("buff_wr_own", c_own, nbytes);
        chk("buff_wr_other", c_oth, 0);
        chk("buff_din", din_bad, 0);
        sd_ack = 1'b0;
    endtask

    initial begin
        int n, tmo_seen;
        reset = 1'b1;
        rq0_lba = '0; rq1_lba = '0;
        rq0_rd = '0; rq0_wr = '0; rq1_rd = '0; rq1_wr = '0;
        rq0_buff_din = '0; rq1_buff_din = '0;
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        do_reset();

        chk("rst_lba", sd_lba, 0);
        chk("rst_strobes", {sd_rd, sd_wr}, 0);
        chk("rst_busy_owner", {busy, owner, timeout_err}, 0);
        chk("rst_acks", {rq0_ack, rq1_ack, rq0_buff_wr, rq1_buff_wr}, 0);

        // Single read on port 0 with a full sector.
        rq0_lba = 32'h123; rq0_rd = 2'b01;
        push(1'b0, 32'h123, 2'b01, 2'b00);
        serve(512, 1'b1);
        chk("rd_latency", lat, 1);
        repeat (4) tick();
        chk("idle_busy", busy, 0);

        // Simultaneous requests right after reset: port 0 first.
        do_reset();
        rq0_lba = 32'hA0; rq0_rd = 2'b01;
        rq1_lba = 32'hB1; rq1_wr = 2'b10;
        push(1'b0, 32'hA0, 2'b01, 2'b00);
        push(1'b1, 32'hB1, 2'b00, 2'b10);
        serve(4, 1'b1);
        serve(8, 1'b1);
        chk("gap_latency", lat, 3);
        repeat (4) tick();

        // Fairness with both ports requesting continuously.
        do_reset();
        rq0_lba = 32'h10; rq0_rd = 2'b10;
        rq1_lba = 32'h20; rq1_wr = 2'b01;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(1'b0, 32'h10, 2'b10, 2'b00);
            else            push(1'b1, 32'h20, 2'b00, 2'b01);
        end
        for (int k = 0; k < 4; k++) serve(2, 1'b0);
        rq0_rd = 2'b00; rq1_wr = 2'b00;
        repeat (4) tick();
        chk("fair_idle", busy, 0);

        // Read wins over write when one port asserts both.
        rq1_lba = 32'h33; rq1_rd = 2'b01; rq1_wr = 2'b01;
        push(1'b1, 32'h33, 2'b01, 2'b00);
        serve(1, 1'b1);
        repeat (4) tick();

        // Reset mid-XFER with the host ack still high.
        rq0_lba = 32'h55; rq0_rd = 2'b01;
        tick();
        chk("pre_rst_grant", sd_rd, 2'b01);
        sd_ack = 1'b1;
        repeat (2) tick();
        chk("pre_rst_ack", rq0_ack, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_out", {sd_lba, sd_rd, sd_wr, busy, owner}, 0);
        chk("mid_rst_ack", {rq0_ack, rq1_ack}, 0);
        repeat (3) tick();
        chk("no_grant_ack_hi", {busy, sd_rd}, 0);
        sd_ack = 1'b0;
        push(1'b0, 32'h55, 2'b01, 2'b00);
        serve(1, 1'b1);
        chk("post_rst_latency", lat, 1);
        repeat (4) tick();

        // Host never acks.
        rq0_lba = 32'h77; rq0_rd = 2'b01;
        tick();
        chk("tmo_grant", sd_rd, 2'b01);
`ifdef U765_SD_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 20);
        chk("tmo_strobes", {sd_rd, sd_wr, rq0_ack}, 0);
        tick();
        chk("tmo_pulse", timeout_err, 0);
        push(1'b0, 32'h77, 2'b01, 2'b00);
        serve(1, 1'b1);
        chk("tmo_regrant", lat, 1);
`else
        tmo_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (timeout_err !== 1'b0 || sd_rd !== 2'b01 || busy !== 1'b1) tmo_seen++;
        end
        chk("no_tmo_1000", tmo_seen, 0);
        push(1'b0, 32'h77, 2'b01, 2'b00);
        serve(1, 1'b1);
        n = 0;
`endif
        repeat (4) tick();
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
